// File: rtl/msj_sched_pkg.sv
// Shared types and constants for the MSJ PD update scheduler.
// Control-mode encodings match the PD controller's mode input.
package msj_sched_pkg;

    localparam logic [1:0] CM_POSITION = 2'b00;
    localparam logic [1:0] CM_VELOCITY = 2'b01;
    localparam logic [1:0] CM_DIRECT   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMMIT,
        S_STROBE,
        S_CAPTURE,
        S_DONE
    } sched_state_t;

    // One motor's setpoint/mode pair, as held in the shadow and active registers.
    typedef struct packed {
        logic signed [31:0] sp;
        logic [1:0]         mode;
    } motor_cfg_t;

    localparam motor_cfg_t CFG_RESET = '{sp: 32'sd0, mode: CM_DIRECT};

endpackage

// File: rtl/msj_period_ticker.sv
// Free-running period counter producing a registered 1-cycle tick.
// period is only looked at when the counter reloads; period==0 parks the counter at 0.
module msj_period_ticker (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] period,
    output logic        tick
);

    logic [31:0] count;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the same pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (count == '0) begin
                if (period != '0) begin
                    tick  <= 1'b1;
                    count <= period - 32'd1;
                end
            end else begin
                count <= count - 32'd1;
            end
        end
    end

endmodule

// File: rtl/msj_pd_update_scheduler.sv
// Sweeps the per-motor PD controllers: commit shadow setpoint/mode, strobe the
// controller, capture its duty, then flag a coherent snapshot at sweep end.
module msj_pd_update_scheduler
    import msj_sched_pkg::*;
#(
    parameter int NUM_MOTORS = 8,
    parameter int IDX_W      = $clog2(NUM_MOTORS)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [31:0]            period,
    input  logic [NUM_MOTORS-1:0]  motor_enable,
    input  logic                   cfg_write,
    input  logic [IDX_W-1:0]       cfg_motor,
    input  logic signed [31:0]     cfg_sp,
    input  logic [1:0]             cfg_mode,
    input  logic signed [31:0]     duty_in [NUM_MOTORS],
    input  logic                   overrun_clear,
    output logic signed [31:0]     sp_out [NUM_MOTORS],
    output logic [1:0]             control_mode_out [NUM_MOTORS],
    output logic [NUM_MOTORS-1:0]  update_controller,
    output logic signed [31:0]     duty_snapshot [NUM_MOTORS],
    output logic                   snapshot_valid,
    output logic                   sweep_busy,
    output logic                   sweep_done,
    output logic                   overrun
);

    sched_state_t          state;
    logic [IDX_W-1:0]      idx;
    motor_cfg_t            shadow [NUM_MOTORS];
    logic [NUM_MOTORS-1:0] pending;
    logic                  tick;
    logic                  last_motor;
    logic                  cfg_in_range;

    assign last_motor   = (int'(idx) == NUM_MOTORS - 1);
    assign cfg_in_range = (int'(cfg_motor) < NUM_MOTORS);
    assign sweep_busy   = (state != S_IDLE);

    msj_period_ticker u_ticker (
        .clock  (clock),
        .reset  (reset),
        .period (period),
        .tick   (tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= S_IDLE;
            idx               <= '0;
            pending           <= '0;
            update_controller <= '0;
            sweep_done        <= 1'b0;
            snapshot_valid    <= 1'b0;
            overrun           <= 1'b0;
            // NOTE: the shadow bank is reset too, because an unwritten motor
            // must read back as direct mode with a zero setpoint.
            for (int i = 0; i < NUM_MOTORS; i++) begin
                shadow[i]           <= CFG_RESET;
                sp_out[i]           <= CFG_RESET.sp;
                control_mode_out[i] <= CFG_RESET.mode;
                duty_snapshot[i]    <= '0;
            end
        end else begin
            update_controller <= '0;
            sweep_done        <= 1'b0;

            // A tick that finds the sweep still running is dropped and remembered.
            if (tick && state != S_IDLE)
                overrun <= 1'b1;
            else if (overrun_clear)
                overrun <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (tick) begin
                        idx   <= '0;
                        state <= S_COMMIT;
                    end
                end

                S_COMMIT: begin
                    if (!motor_enable[idx]) begin
                        if (last_motor) begin
                            state      <= S_DONE;
                            sweep_done <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        if (pending[idx]) begin
                            sp_out[idx]           <= shadow[idx].sp;
                            control_mode_out[idx] <= shadow[idx].mode;
                            pending[idx]          <= 1'b0;
                        end
                        update_controller[idx] <= 1'b1;
                        state                  <= S_STROBE;
                    end
                end

                S_STROBE: state <= S_CAPTURE;

                S_CAPTURE: begin
                    duty_snapshot[idx] <= duty_in[idx];
                    if (last_motor) begin
                        state      <= S_DONE;
                        sweep_done <= 1'b1;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= S_COMMIT;
                    end
                end

                S_DONE: begin
                    snapshot_valid <= 1'b1;
                    state          <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase

            // Placed after the commit so a same-cycle write re-arms pending for next sweep.
            if (cfg_write && cfg_in_range) begin
                shadow[cfg_motor]  <= '{sp: cfg_sp, mode: cfg_mode};
                pending[cfg_motor] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_msj_pd_update_scheduler.sv
// Self-checking bench: event-level sweep model feeds expectation queues that a
// separate monitor pops and compares against the scheduler's outputs.
module tb_msj_pd_update_scheduler;
    import msj_sched_pkg::*;

    localparam int N = 8;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [31:0]         period = '0;
    logic [N-1:0]        motor_enable = '1;
    logic                cfg_write = 1'b0;
    logic [2:0]          cfg_motor = '0;
    logic signed [31:0]  cfg_sp = '0;
    logic [1:0]          cfg_mode = '0;
    logic signed [31:0]  duty_in [N];
    logic                overrun_clear = 1'b0;
    logic signed [31:0]  sp_out [N];
    logic [1:0]          control_mode_out [N];
    logic [N-1:0]        update_controller;
    logic signed [31:0]  duty_snapshot [N];
    logic                snapshot_valid, sweep_busy, sweep_done, overrun;

    msj_pd_update_scheduler #(.NUM_MOTORS(N)) dut (
        .clock             (clock),
        .reset             (reset),
        .period            (period),
        .motor_enable      (motor_enable),
        .cfg_write         (cfg_write),
        .cfg_motor         (cfg_motor),
        .cfg_sp            (cfg_sp),
        .cfg_mode          (cfg_mode),
        .duty_in           (duty_in),
        .overrun_clear     (overrun_clear),
        .sp_out            (sp_out),
        .control_mode_out  (control_mode_out),
        .update_controller (update_controller),
        .duty_snapshot     (duty_snapshot),
        .snapshot_valid    (snapshot_valid),
        .sweep_busy        (sweep_busy),
        .sweep_done        (sweep_done),
        .overrun           (overrun)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int c, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
        end
    endtask

    // Staged stimulus, applied to the DUT at the next falling edge.
    logic               s_reset = 1'b1;
    logic [31:0]        s_period = '0;
    logic [N-1:0]       s_enable = '1;
    logic signed [31:0] s_duty [N];

    // ---------------- reference model ----------------
    typedef struct { int cyc; int motor; } event_t;
    typedef struct { int cyc; logic [N-1:0][31:0] snap; } done_t;

    logic signed [31:0] m_shadow_sp [N];
    logic [1:0]         m_shadow_mode [N];
    bit                 m_pending [N];
    logic signed [31:0] m_sp [N];
    logic [1:0]         m_mode [N];
    logic [N-1:0][31:0] m_snap_idle, sweep_snap;
    bit                 exp_busy, exp_ov, exp_valid, tick_next;
    int                 next_tick, cur_s, cur_e;
    event_t             plan_q [$];
    event_t             pulse_q [$];
    done_t              done_q [$];

    task automatic init_model(input int c);
        for (int i = 0; i < N; i++) begin
            m_shadow_sp[i]   = 0;
            m_shadow_mode[i] = CM_DIRECT;
            m_pending[i]     = 0;
            m_sp[i]          = 0;
            m_mode[i]        = CM_DIRECT;
        end
        m_snap_idle = '0;
        sweep_snap  = '0;
        exp_busy  = 0;
        exp_ov    = 0;
        exp_valid = 0;
        tick_next = 0;
        next_tick = c + 1;
        cur_s     = -10;
        cur_e     = -10;
        plan_q.delete();
        pulse_q.delete();
        done_q.delete();
    endtask

    // Lay out a whole sweep: enabled motors take 3 cycles, skipped ones 1, plus a DONE cycle.
    task automatic plan_sweep(input int s);
        int off = s;
        done_t d;
        sweep_snap = m_snap_idle;
        for (int m = 0; m < N; m++) begin
            if (motor_enable[m]) begin
                plan_q.push_back('{off, m});
                sweep_snap[m] = duty_in[m];
                off += 3;
            end else begin
                off += 1;
            end
        end
        cur_s  = s;
        cur_e  = off;
        d.cyc  = off;
        d.snap = sweep_snap;
        done_q.push_back(d);
    endtask

    // Called once per cycle c after that cycle's inputs are driven; produces cycle c+1 expectations.
    task automatic model_step(input int c);
        bit ov_set;
        event_t k;
        if (reset) begin
            init_model(c);
            return;
        end
        if (c == cur_e) begin
            m_snap_idle = sweep_snap;
            exp_valid   = 1;
        end
        ov_set = 0;
        if (tick_next) begin
            if (c >= cur_s && c <= cur_e) ov_set = 1;
            else plan_sweep(c + 1);
        end
        if (ov_set) exp_ov = 1;
        else if (overrun_clear) exp_ov = 0;
        while (plan_q.size() > 0 && plan_q[0].cyc <= c) begin
            k = plan_q.pop_front();
            if (m_pending[k.motor]) begin
                m_sp[k.motor]      = m_shadow_sp[k.motor];
                m_mode[k.motor]    = m_shadow_mode[k.motor];
                m_pending[k.motor] = 0;
            end
            pulse_q.push_back('{k.cyc + 1, k.motor});
        end
        if (cfg_write) begin
            m_shadow_sp[int'(cfg_motor)]   = cfg_sp;
            m_shadow_mode[int'(cfg_motor)] = cfg_mode;
            m_pending[int'(cfg_motor)]     = 1;
        end
        tick_next = (c + 1 >= next_tick) && (period != 0);
        if (tick_next) next_tick = c + 1 + int'(period);
        exp_busy = (c + 1 >= cur_s) && (c + 1 <= cur_e);
    endtask

    // ---------------- monitor ----------------
    task automatic check_cycle(input int n);
        event_t p;
        done_t  d;
        if (update_controller != '0) begin
            if (pulse_q.size() == 0) begin
                check("pulse_unexpected", n, 64'(update_controller), 64'd0);
            end else begin
                p = pulse_q.pop_front();
                check("pulse_motor", n, 64'(update_controller), 64'(1) << p.motor);
                check("pulse_cycle", n, 64'(n), 64'(p.cyc));
            end
        end else if (pulse_q.size() > 0 && pulse_q[0].cyc <= n) begin
            p = pulse_q.pop_front();
            check("pulse_missing", n, 64'(update_controller), 64'(1) << p.motor);
        end

        if (sweep_done) begin
            if (done_q.size() == 0) begin
                check("done_unexpected", n, 64'(sweep_done), 64'd0);
            end else begin
                d = done_q.pop_front();
                check("done_cycle", n, 64'(n), 64'(d.cyc));
                for (int i = 0; i < N; i++)
                    check("done_snapshot", n, {32'd0, duty_snapshot[i]}, {32'd0, d.snap[i]});
            end
        end else if (done_q.size() > 0 && done_q[0].cyc <= n) begin
            d = done_q.pop_front();
            check("done_missing", n, 64'(sweep_done), 64'd1);
        end

        check("sweep_busy", n, 64'(sweep_busy), 64'(exp_busy));
        check("overrun", n, 64'(overrun), 64'(exp_ov));
        check("snapshot_valid", n, 64'(snapshot_valid), 64'(exp_valid));
        for (int i = 0; i < N; i++)
            check("sp_mode", n, {30'd0, sp_out[i], control_mode_out[i]}, {30'd0, m_sp[i], m_mode[i]});
        if (!exp_busy)
            for (int i = 0; i < N; i++)
                check("idle_snapshot", n, {32'd0, duty_snapshot[i]}, {32'd0, m_snap_idle[i]});
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #1;
            check_cycle(cyc);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycle(input bit wr = 0, input int m = 0, input logic signed [31:0] sp = 0,
                         input logic [1:0] md = 0, input bit clr = 0);
        @(negedge clock);
        reset        = s_reset;
        period       = s_period;
        motor_enable = s_enable;
        for (int i = 0; i < N; i++) duty_in[i] = s_duty[i];
        cfg_write     = wr;
        cfg_motor     = 3'(m);
        cfg_sp        = sp;
        cfg_mode      = md;
        overrun_clear = clr;
        model_step(cyc);
    endtask

    task automatic wait_until(input int target);
        int guard = 0;
        while (cyc + 1 < target && guard < 300) begin
            cycle();
            guard++;
        end
        check("wait_target", cyc, 64'(cyc + 1), 64'(target));
    endtask

    task automatic wait_new_sweep();
        int t0 = cyc;
        int guard = 0;
        while (cur_s <= t0 && guard < 300) begin
            cycle();
            guard++;
        end
        check("sweep_start_timeout", cyc, 64'(cur_s > t0), 64'd1);
    endtask

    task automatic stop_and_idle();
        int guard = 0;
        s_period = 0;
        cycle();
        while (cyc + 1 <= cur_e && guard < 300) begin
            cycle();
            guard++;
        end
        check("idle_timeout", cyc, 64'(cyc + 1 > cur_e), 64'd1);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            s_duty[i]  = 0;
            duty_in[i] = 0;
        end
        init_model(0);

        repeat (4) cycle();
        s_reset = 0;
        repeat (100) cycle();

        // Full sweeps, all enabled, with a same-cycle commit/write collision and a late write.
        for (int i = 0; i < N; i++) s_duty[i] = i * 100;
        cycle(1, 2, -32'sd777, CM_VELOCITY);
        s_period = 40;
        wait_new_sweep();
        wait_until(cur_s + 6);
        cycle(1, 2, 32'sd1234, CM_POSITION);
        wait_until(cur_s + 12);
        cycle(1, 3, 32'sd500, CM_POSITION);
        repeat (100) cycle();
        stop_and_idle();

        // Randomised phases: enables, duties, period and config traffic.
        for (int r = 0; r < 4; r++) begin
            s_enable = N'($urandom);
            for (int i = 0; i < N; i++) s_duty[i] = $urandom;
            s_period = $urandom_range(8, 40);
            for (int k = 0; k < 150; k++) begin
                if ($urandom_range(0, 3) == 0)
                    cycle(1, $urandom_range(0, N - 1), $urandom, 2'($urandom_range(0, 2)),
                          $urandom_range(0, 15) == 0);
                else
                    cycle(0, 0, 0, 0, $urandom_range(0, 15) == 0);
            end
            stop_and_idle();
        end

        // Sweep longer than the period: sticky overrun, then clear.
        s_enable = 8'b0000_0101;
        s_period = 10;
        repeat (60) cycle();
        cycle(0, 0, 0, 0, 1);
        repeat (30) cycle();
        stop_and_idle();

        // Reset while motor 4's update pulse is high.
        s_enable = '1;
        s_period = 40;
        wait_new_sweep();
        wait_until(cur_s + 13);
        s_reset = 1;
        cycle();
        s_reset = 0;
        repeat (60) cycle();
        stop_and_idle();
        repeat (2) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
